// File: rtl/cpu_pc_stack_if.sv
// Fetch/decode-side bus of the MCS8 program-counter / return-stack stage.
// master: decode and fetch memory (drive redirect decisions and acks).
// slave : cpu_pc_stack (drives fetch address, request, flush, stack error).
interface cpu_pc_stack_if #(
  parameter int PC_W = 14
) ();
  logic            IF_ACK_I;
  logic            STALL_I;
  logic            D_VLD_I;
  logic            COND_JMP_I;
  logic            COND_CAL_I;
  logic            COND_RET_I;
  logic            RST_INS_I;
  logic [2:0]      RST_AAA_I;
  logic [PC_W-1:0] D_TARGET_I;
  logic [PC_W-1:0] D_NEXT_PC_I;
  logic [PC_W-1:0] PC_O;
  logic            IF_REQ_O;
  logic            FLUSH_O;
  logic            STK_ERR_O;

  modport master (
    output IF_ACK_I, STALL_I, D_VLD_I, COND_JMP_I, COND_CAL_I, COND_RET_I,
           RST_INS_I, RST_AAA_I, D_TARGET_I, D_NEXT_PC_I,
    input  PC_O, IF_REQ_O, FLUSH_O, STK_ERR_O
  );

  modport slave (
    input  IF_ACK_I, STALL_I, D_VLD_I, COND_JMP_I, COND_CAL_I, COND_RET_I,
           RST_INS_I, RST_AAA_I, D_TARGET_I, D_NEXT_PC_I,
    output PC_O, IF_REQ_O, FLUSH_O, STK_ERR_O
  );
endinterface

// File: rtl/cpu_pc_stack.sv
// Program counter and 8008-style circular return-address stack for the MCS8
// core. Accepts resolved JMP/CAL/RET/RST decisions from decode, redirects
// fetch and raises a one-cycle flush after each redirect.
// Optional: define STACK_ERR_DET_EN to add an occupancy counter that flags
// stack overflow/underflow on STK_ERR_O (sticky until reset).
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | in reset / first cycle after reset, no fetch request
// S_FETCH | fetching; IF_REQ_O held high from here on
module cpu_pc_stack #(
  parameter int PC_W   = 14,
  parameter int STK_AW = 3
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  cpu_pc_stack_if.slave  bus
);

  localparam int DEPTH = 2**STK_AW;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [STK_AW-1:0] sp_q, sp_d;
  logic              flush_q, flush_d;
  logic [PC_W-1:0]   stack_q [DEPTH];

  logic              redirect;
  logic              push;
  logic              pop;
  logic [STK_AW-1:0] sp_dec;
  logic [PC_W-1:0]   rst_vec;

  // Redirect decode, PC/SP next-state and fetch FSM.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    push     = 1'b0;
    pop      = 1'b0;
    sp_dec   = sp_q - 1'b1;
    rst_vec  = '0;
    rst_vec[5:0] = {bus.RST_AAA_I, 3'b000};

    redirect = bus.D_VLD_I & ~bus.STALL_I &
               (bus.COND_JMP_I | bus.COND_CAL_I | bus.COND_RET_I | bus.RST_INS_I);
    flush_d  = redirect;

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    // Redirect wins over sequential increment; the acked byte is flushed.
    if (redirect) begin
      if (bus.RST_INS_I) begin
        push = 1'b1;
        pc_d = rst_vec;
      end else if (bus.COND_CAL_I) begin
        push = 1'b1;
        pc_d = bus.D_TARGET_I;
      end else if (bus.COND_JMP_I) begin
        pc_d = bus.D_TARGET_I;
      end else begin
        pop  = 1'b1;
        pc_d = stack_q[sp_dec];
      end
    end else if (bus.IF_REQ_O & bus.IF_ACK_I & ~bus.STALL_I) begin
      pc_d = pc_q + 1'b1;
    end

    if (push) begin
      sp_d = sp_q + 1'b1;
    end else if (pop) begin
      sp_d = sp_dec;
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      flush_q <= flush_d;
    end
  end

  // Stack array is not reset; a CAL writes here and a following RET reads it back.
  always_ff @(posedge CLK_I) begin
    if (push) begin
      stack_q[sp_q] <= bus.D_NEXT_PC_I;
    end
  end

  assign bus.PC_O     = pc_q;
  assign bus.IF_REQ_O = (state_q == S_FETCH);
  assign bus.FLUSH_O  = flush_q;

`ifdef STACK_ERR_DET_EN
  localparam logic [STK_AW:0] OCC_FULL = (STK_AW+1)'(DEPTH);

  logic [STK_AW:0] occ_q, occ_d;
  logic            err_q, err_d;

  // Saturating occupancy; wrap of SP itself is untouched, only flagged.
  always_comb begin
    occ_d = occ_q;
    err_d = err_q;
    if (push) begin
      if (occ_q == OCC_FULL) err_d = 1'b1;
      else                   occ_d = occ_q + 1'b1;
    end else if (pop) begin
      if (occ_q == '0) err_d = 1'b1;
      else             occ_d = occ_q - 1'b1;
    end
  end

  // Occupancy and sticky error flag registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  assign bus.STK_ERR_O = err_q;
`else
  assign bus.STK_ERR_O = 1'b0;
`endif

endmodule
